// File: rtl/fetch_pkg.sv
// Core-wide fetch types and constants.
// PC width, reset PC, fetch entry bundle, NOP encoding.
package fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries.
// Ports: push, pop, flush, wr_data, rd_data, full, empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wr_data,
  output entry_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Head is forced to zero while empty so
  // the outputs are defined out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads imem, buffers {pc, inst}.
// Ports: clk/rst_n, imem addr/inst, redirect, valid/ready head.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(fetch_pkg::RESET_PC),
  parameter int DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]       i_imem_inst,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_inst,
  input  logic              i_ready
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic              full;
  logic              empty;
  logic              deq;
  logic              enq;
  entry_t            wr_entry;
  entry_t            head;
  logic              unused_lsb;

  assign unused_lsb = ^i_redirect_pc[1:0];

  assign o_valid = ~empty;
  assign deq     = o_valid & i_ready;
  // A pop this cycle frees a slot, so a full
  // FIFO still accepts a word without a bubble.
  assign enq     = (~full | deq) & ~i_redirect_valid;

  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = pc;
    wr_entry.inst = i_imem_inst;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      pc <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (enq) begin
      pc <= pc + ADDR_W'(4);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (enq),
    .pop     (deq),
    .flush   (i_redirect_valid),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign o_imem_addr = pc;
  assign o_pc        = head.pc;
  assign o_inst      = head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Cycle tables plus a queue scoreboard of fetched entries.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redir;
  logic [31:0] rpc;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  // memory word equals its own address
  assign imem_inst = imem_addr;

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_addr      (imem_addr),
    .i_imem_inst      (imem_inst),
    .i_redirect_valid (redir),
    .i_redirect_pc    (rpc),
    .o_valid          (valid),
    .o_pc             (pc),
    .o_inst           (inst),
    .i_ready          (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          mcount;
  logic [31:0] mpc;

  always @(negedge clk) begin
    exp_t e;
    logic mdeq;
    logic menq;
    if (!rst_n) begin
      sb.delete();
      mcount = 0;
      mpc    = RST_PC;
    end else begin
      check("mon_valid", 32'(valid),
            32'(mcount != 0));
      check("mon_addr", imem_addr, mpc);
      mdeq = (mcount != 0) && ready;
      if (mdeq && sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_inst", inst, e.inst);
      end
      if (redir) begin
        sb.delete();
        mcount = 0;
        mpc    = rpc & ~32'h3;
      end else begin
        menq = (mcount < DEPTH) || mdeq;
        if (menq) begin
          sb.push_back('{pc: mpc, inst: mpc});
          mpc = mpc + 32'd4;
        end
        mcount = mcount + int'(menq) - int'(mdeq);
      end
    end
  end

  // ---------------- cycle tables ----------------
  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(
    input logic        r,
    input logic        d,
    input logic [31:0] t,
    input logic        v,
    input logic [31:0] p,
    input logic [31:0] a
  );
    vec_t x;
    x.rdy = r; x.redir = d; x.rpc = t;
    x.ev = v; x.epc = p; x.eaddr = a;
    return x;
  endfunction

  // Checks outputs of the current cycle, then drives
  // this row's inputs across the next rising edge.
  task automatic apply(input string tag, input vec_t x);
    check({tag, "_valid"}, 32'(valid), 32'(x.ev));
    check({tag, "_addr"}, imem_addr, x.eaddr);
    if (x.ev) begin
      check({tag, "_pc"}, pc, x.epc);
      check({tag, "_inst"}, inst, x.epc);
    end
    ready = x.rdy;
    redir = x.redir;
    rpc   = x.rpc;
    @(posedge clk);
    #1;
  endtask

  vec_t va[23];
  vec_t vb[9];

  initial begin
    va[0]  = mk(1, 0, 0, 0, 0, 32'h0);
    va[1]  = mk(1, 0, 0, 1, 32'h0, 32'h4);
    va[2]  = mk(1, 0, 0, 1, 32'h4, 32'h8);
    va[3]  = mk(1, 0, 0, 1, 32'h8, 32'hC);
    va[4]  = mk(1, 0, 0, 1, 32'hC, 32'h10);
    va[5]  = mk(1, 1, 32'h101, 1, 32'h10, 32'h14);
    va[6]  = mk(1, 0, 0, 0, 0, 32'h100);
    va[7]  = mk(1, 0, 0, 1, 32'h100, 32'h104);
    va[8]  = mk(0, 0, 0, 1, 32'h104, 32'h108);
    va[9]  = mk(0, 0, 0, 1, 32'h104, 32'h10C);
    va[10] = mk(0, 0, 0, 1, 32'h104, 32'h10C);
    va[11] = mk(0, 1, 32'h200, 1, 32'h104, 32'h10C);
    va[12] = mk(0, 0, 0, 0, 0, 32'h200);
    va[13] = mk(0, 0, 0, 1, 32'h200, 32'h204);
    va[14] = mk(0, 0, 0, 1, 32'h200, 32'h208);
    va[15] = mk(1, 0, 0, 1, 32'h200, 32'h208);
    va[16] = mk(1, 0, 0, 1, 32'h204, 32'h20C);
    va[17] = mk(1, 1, 32'hFFFF_FFFB,
                1, 32'h208, 32'h210);
    va[18] = mk(1, 0, 0, 0, 0, 32'hFFFF_FFF8);
    va[19] = mk(1, 0, 0, 1, 32'hFFFF_FFF8,
                32'hFFFF_FFFC);
    va[20] = mk(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    va[21] = mk(1, 0, 0, 1, 32'h0, 32'h4);
    va[22] = mk(1, 0, 0, 1, 32'h4, 32'h8);

    vb[0] = mk(0, 0, 0, 0, 0, 32'h0);
    vb[1] = mk(0, 0, 0, 1, 32'h0, 32'h4);
    vb[2] = mk(0, 0, 0, 1, 32'h0, 32'h8);
    vb[3] = mk(0, 0, 0, 1, 32'h0, 32'h8);
    vb[4] = mk(0, 0, 0, 1, 32'h0, 32'h8);
    vb[5] = mk(1, 0, 0, 1, 32'h0, 32'h8);
    vb[6] = mk(1, 0, 0, 1, 32'h4, 32'hC);
    vb[7] = mk(1, 0, 0, 1, 32'h8, 32'h10);
    vb[8] = mk(1, 0, 0, 1, 32'hC, 32'h14);

    rst_n = 1'b0;
    ready = 1'b1;
    redir = 1'b0;
    rpc   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    rst_n = 1'b1;

    foreach (va[i]) apply($sformatf("a%0d", i), va[i]);

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    ready = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_addr", imem_addr, RST_PC);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vb[i]) apply($sformatf("b%0d", i), vb[i]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that owns the program counter, drives the instruction memory address and buffers the returned words for decode. The instruction memory is a combinational read, so each fetched word is captured together with its PC into a small FIFO. Decode pulls {pc, inst} pairs over a valid/ready handshake, and execute redirects the stream on taken branches and jumps.

## Interface
- ADDR_W, 32: PC and instruction memory address width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 2: fetch FIFO entries; must be a power of two, 2 or more.
- i_clk  in  1: clock, rising edge.
- i_rst_n  in  1: reset, asynchronous, active-low.
- o_imem_addr  out  ADDR_W: address to instruction memory; always equals the PC register.
- i_imem_inst  in  32: instruction word returned combinationally for o_imem_addr.
- i_redirect_valid  in  1: single-cycle request to restart fetch.
- i_redirect_pc  in  ADDR_W: redirect target; bits [1:0] are ignored and treated as 0.
- o_valid  out  1: FIFO head holds a valid entry.
- o_pc  out  ADDR_W: PC of the head entry.
- o_inst  out  32: instruction of the head entry.
- i_ready  in  1: decode accepts the head this cycle.

## Operation
- Registers: pc, FIFO storage of {pc, inst} × DEPTH, rd_ptr, wr_ptr, count (log2(DEPTH)+1 bits).
- deq = o_valid & i_ready.
- can_enq = (count < DEPTH) | deq.
- enq = can_enq & ~i_redirect_valid.
- On enq: write {pc, i_imem_inst} at wr_ptr, then pc <= pc + 4 (modulo 2^ADDR_W). The wrap from 32'hFFFF_FFFC to 0 is legal.
- On deq: rd_ptr advances.
- count updates by enq − deq.
- Pointers wrap modulo DEPTH.
- When the FIFO is full and no deq occurs: pc holds, o_imem_addr holds, and nothing is written.
- Redirect, when i_redirect_valid=1:
  - A deq in the same cycle is honoured, so the head is consumed.
  - At the edge: count <= 0, rd_ptr <= wr_ptr <= 0, pc <= {i_redirect_pc[ADDR_W-1:2], 2'b00}.
  - No enqueue occurs that cycle.
  - Redirect has priority over everything else.
- o_valid = (count != 0). o_pc and o_inst are driven from the entry at rd_ptr.
- Once o_valid is asserted, o_pc and o_inst stay stable until deq or redirect. The FIFO never reorders or drops entries except on redirect.
- No state machine beyond the FIFO occupancy. The states EMPTY / PARTIAL / FULL follow from count.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - pc = RESET_PC, count = 0, pointers = 0, o_valid = 0.
  - o_imem_addr = RESET_PC.
  - o_pc and o_inst have don't-care content but are driven to 0.
- First valid: the first rising edge after i_rst_n rises enqueues RESET_PC. o_valid goes to 1 in the next cycle.
- Fetch-to-valid latency: 1 cycle. Sustained throughput: 1 instruction per cycle with i_ready held at 1.
- Redirect penalty:
  - Redirect asserted in cycle t.
  - Cycle t+1: o_valid=0 and o_imem_addr = target.
  - Cycle t+2: o_valid=1 with o_pc = target.
- Full with deq in the same cycle: enqueue still occurs, so there is no bubble.
- Reset asserted mid-stream: all entries are lost immediately and asynchronously, and pc returns to RESET_PC.
- No combinational path from i_ready or i_redirect_valid to o_valid, o_pc or o_inst.
- Combinational paths exist from i_ready to the enqueue decision only. o_imem_addr is a register output.

## Structure
- Shared package (core-wide):
  - PC width constant.
  - RESET_PC constant.
  - Typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [31:0] inst;}.
  - NOP encoding 32'h0000_0013, used by decode on bubbles.
- One natural sub-module: fetch_fifo.
  - A generic DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty.
  - fetch_unit keeps the pc register and the enqueue/redirect logic.

## Test plan
- Reset release with i_ready=1 and memory word = address: o_valid rises 1 cycle after release. o_pc reads 0, 4, 8, … on consecutive cycles, and o_inst == o_pc each cycle.
- Backpressure: hold i_ready=0 for 5 cycles after reset.
  - count saturates at 2 and o_imem_addr sticks at 8.
  - Release i_ready: entries PC 0, 4, 8 appear in order with no gaps.
- Redirect to 32'h0000_0101 while i_ready=1 with the head at PC 0x10:
  - The head at 0x10 is consumed.
  - Next cycle: o_valid=0 and o_imem_addr=0x100.
  - Following cycle: o_pc=0x100.
- Redirect while the FIFO is full and i_ready=0: both entries are discarded, and the next valid entry has the target PC 2 cycles later.
- PC wrap: redirect to 32'hFFFF_FFF8 with i_ready=1. Observed o_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert i_rst_n=0 asynchronously mid-stream between clock edges:
  - o_valid drops immediately and o_imem_addr = RESET_PC.
  - After release, the stream restarts at RESET_PC.
